// File: rtl/xbar_route_ctrl_if.sv
// xbar_route_ctrl_if: request, control-word and connection-status bundle between
// the route-control stage (slave) and its requesters/crossbar side (master).
interface xbar_route_ctrl_if #(
  parameter int unsigned N_INPUTS          = 2,
  parameter int unsigned N_OUTPUTS         = 2,
  parameter int unsigned CONTROL_BIT_WIDTH = 42,
  parameter int unsigned LEN_W             = 8
);
  localparam int unsigned SW_O = (N_OUTPUTS > 2) ? $clog2(N_OUTPUTS) : 1;

  logic [N_INPUTS-1:0]          req_val;
  logic [N_INPUTS*SW_O-1:0]     req_dest;
  logic [N_INPUTS*LEN_W-1:0]    req_len;
  logic                         xfer;
  logic [CONTROL_BIT_WIDTH-1:0] control;
  logic                         control_val;
  logic                         control_rdy;
  logic [N_INPUTS-1:0]          grant;
  logic                         busy;
  logic                         timeout;

  modport master (
    output req_val, req_dest, req_len, xfer, control_rdy,
    input  control, control_val, grant, busy, timeout
  );

  modport slave (
    input  req_val, req_dest, req_len, xfer, control_rdy,
    output control, control_val, grant, busy, timeout
  );
endinterface

// File: rtl/xbar_route_ctrl.sv
// xbar_route_ctrl: round-robin selection of one head packet, control-word issue over
// val/rdy, and connection hold until the last beat. Watchdog: define XBAR_ROUTE_TIMEOUT_EN.
module xbar_route_ctrl #(
  parameter int unsigned N_INPUTS          = 2,
  parameter int unsigned N_OUTPUTS         = 2,
  parameter int unsigned CONTROL_BIT_WIDTH = 42,
  parameter int unsigned LEN_W             = 8
`ifdef XBAR_ROUTE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES  = 255
`endif
) (
  input  logic             clk,
  input  logic             reset,
  xbar_route_ctrl_if.slave bus
);
  localparam int unsigned SW_I = (N_INPUTS > 2) ? $clog2(N_INPUTS) : 1;
  localparam int unsigned SW_O = (N_OUTPUTS > 2) ? $clog2(N_OUTPUTS) : 1;
  localparam int unsigned CW   = CONTROL_BIT_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;

`ifdef XBAR_ROUTE_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
`endif

  logic [1:0]          r_state;
  logic [SW_I-1:0]     r_rr_ptr;
  logic [SW_I-1:0]     r_sel_in;
  logic [LEN_W-1:0]    r_remaining;
  logic [CW-1:0]       r_control;
  logic                r_control_val;
  logic [N_INPUTS-1:0] r_grant;
  logic                r_busy;

  logic [1:0]          w_state_nxt;
  logic [SW_I-1:0]     w_rr_nxt;
  logic [SW_I-1:0]     w_sel_in_nxt;
  logic [LEN_W-1:0]    w_rem_nxt;
  logic [CW-1:0]       w_control_nxt;
  logic                w_control_val_nxt;
  logic [N_INPUTS-1:0] w_grant_nxt;
  logic                w_busy_nxt;

  logic [SW_I-1:0]     w_pick;
  logic                w_found;
  logic [SW_O-1:0]     w_dest;
  logic [LEN_W-1:0]    w_len;
  logic [CW-1:0]       w_word;
  logic [SW_I-1:0]     w_rr_after;

`ifdef XBAR_ROUTE_TIMEOUT_EN
  logic [TW-1:0]       r_idle_cnt;
  logic                r_timeout;
  logic [TW-1:0]       w_idle_nxt;
  logic                w_timeout_nxt;
`endif

  // Round-robin scan: iterate offsets high-to-low so the smallest offset from rr_ptr wins.
  always_comb begin : pick
    logic [SW_I:0] idx;
    w_pick  = r_rr_ptr;
    w_found = 1'b0;
    idx     = '0;
    for (int k = int'(N_INPUTS) - 1; k >= 0; k--) begin
      idx = {1'b0, r_rr_ptr} + (SW_I+1)'(k);
      if (idx >= (SW_I+1)'(N_INPUTS)) begin
        idx = idx - (SW_I+1)'(N_INPUTS);
      end
      if (bus.req_val[idx[SW_I-1:0]]) begin
        w_pick  = idx[SW_I-1:0];
        w_found = 1'b1;
      end
    end
  end

  // Fields of the selected request and the control word they form.
  always_comb begin : sel_fields
    w_dest     = bus.req_dest[32'(w_pick) * SW_O +: SW_O];
    w_len      = bus.req_len[32'(w_pick) * LEN_W +: LEN_W];
    w_word     = (CW'(w_pick) << (CW - SW_I)) | (CW'(w_dest) << (CW - SW_I - SW_O));
    w_rr_after = (r_sel_in == SW_I'(N_INPUTS - 1)) ? '0 : r_sel_in + SW_I'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin : next_state
    w_state_nxt       = r_state;
    w_rr_nxt          = r_rr_ptr;
    w_sel_in_nxt      = r_sel_in;
    w_rem_nxt         = r_remaining;
    w_control_nxt     = r_control;
    w_control_val_nxt = r_control_val;
    w_grant_nxt       = r_grant;
    w_busy_nxt        = r_busy;
`ifdef XBAR_ROUTE_TIMEOUT_EN
    w_idle_nxt        = r_idle_cnt;
    w_timeout_nxt     = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt       = ST_ISSUE;
          w_sel_in_nxt      = w_pick;
          w_rem_nxt         = (w_len == '0) ? LEN_W'(1) : w_len;
          w_control_nxt     = w_word;
          w_control_val_nxt = 1'b1;
        end
      end

      ST_ISSUE: begin
        if (bus.control_rdy) begin
          w_state_nxt       = ST_XFER;
          w_control_val_nxt = 1'b0;
          w_grant_nxt       = N_INPUTS'(1) << r_sel_in;
          w_busy_nxt        = 1'b1;
`ifdef XBAR_ROUTE_TIMEOUT_EN
          w_idle_nxt        = '0;
`endif
        end
      end

      ST_XFER: begin
        if (bus.xfer) begin
          w_rem_nxt = r_remaining - LEN_W'(1);
`ifdef XBAR_ROUTE_TIMEOUT_EN
          w_idle_nxt = '0;
`endif
          if (r_remaining == LEN_W'(1)) begin
            w_state_nxt   = ST_IDLE;
            w_rr_nxt      = w_rr_after;
            w_control_nxt = '0;
            w_grant_nxt   = '0;
            w_busy_nxt    = 1'b0;
          end
        end
`ifdef XBAR_ROUTE_TIMEOUT_EN
        // Stalled path: abort the connection and let the next input arbitrate.
        else if (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          w_timeout_nxt = 1'b1;
          w_idle_nxt    = '0;
          w_state_nxt   = ST_IDLE;
          w_rr_nxt      = w_rr_after;
          w_control_nxt = '0;
          w_grant_nxt   = '0;
          w_busy_nxt    = 1'b0;
        end else begin
          w_idle_nxt = r_idle_cnt + TW'(1);
        end
`endif
      end

      default: begin
        w_state_nxt       = ST_IDLE;
        w_control_nxt     = '0;
        w_control_val_nxt = 1'b0;
        w_grant_nxt       = '0;
        w_busy_nxt        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin : regs
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_sel_in      <= '0;
      r_remaining   <= '0;
      r_control     <= '0;
      r_control_val <= 1'b0;
      r_grant       <= '0;
      r_busy        <= 1'b0;
`ifdef XBAR_ROUTE_TIMEOUT_EN
      r_idle_cnt    <= '0;
      r_timeout     <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_nxt;
      r_sel_in      <= w_sel_in_nxt;
      r_remaining   <= w_rem_nxt;
      r_control     <= w_control_nxt;
      r_control_val <= w_control_val_nxt;
      r_grant       <= w_grant_nxt;
      r_busy        <= w_busy_nxt;
`ifdef XBAR_ROUTE_TIMEOUT_EN
      r_idle_cnt    <= w_idle_nxt;
      r_timeout     <= w_timeout_nxt;
`endif
    end
  end

  assign bus.control     = r_control;
  assign bus.control_val = r_control_val;
  assign bus.grant       = r_grant;
  assign bus.busy        = r_busy;
`ifdef XBAR_ROUTE_TIMEOUT_EN
  assign bus.timeout     = r_timeout;
`else
  assign bus.timeout     = 1'b0;
`endif

endmodule
